// File: rtl/trap_ctrl_pkg.sv
// Shared constants for the machine-mode trap controller: CSR addresses,
// exception cause codes, mstatus bit positions and sequencer states.
package trap_ctrl_pkg;

  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;
  localparam logic [11:0] CsrMtval   = 12'h343;

  localparam int unsigned ExcIllegal    = 2;
  localparam int unsigned ExcBreakpoint = 3;
  localparam int unsigned ExcEcallM     = 11;

  localparam int unsigned MstatusMie   = 3;
  localparam int unsigned MstatusMpie  = 7;
  localparam int unsigned MstatusMppLo = 11;
  localparam int unsigned MstatusMppHi = 12;

  typedef enum logic [2:0] {
    StIdle,
    StWEpc,
    StWCause,
    StWTval,
    StWStat,
    StWRet
  } trap_state_e;

endpackage

// File: rtl/trap_irq_arb.sv
// Fixed-priority interrupt encoder: the highest set request index wins.
module trap_irq_arb #(
  parameter int unsigned IRQ_W = 16,
  parameter int unsigned CodeW = 4
) (
  input  logic [IRQ_W-1:0] req_i,
  output logic             valid_o,
  output logic [CodeW-1:0] code_o
);

  always_comb begin
    valid_o = 1'b0;
    code_o  = '0;
    // Ascending scan so the last (highest) hit overrides lower ones.
    for (int k = 0; k < IRQ_W; k++) begin
      if (req_i[k]) begin
        valid_o = 1'b1;
        code_o  = CodeW'(k);
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: arbitrates interrupts and system events, writes
// mepc/mcause/mtval/mstatus one per cycle, then flushes and redirects.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned IRQ_W  = 16,
  parameter int unsigned CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IRQ_W-1:0]  irq_i,
  input  logic              id_valid_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [31:0]       id_inst_i,
  input  logic              id_ecall_i,
  input  logic              id_ebreak_i,
  input  logic              id_illegal_i,
  input  logic              id_mret_i,
  input  logic              pipe_busy_i,
  input  logic [XLEN-1:0]   csr_mtvec_i,
  input  logic [XLEN-1:0]   csr_mepc_i,
  input  logic [XLEN-1:0]   csr_mstatus_i,
  input  logic [XLEN-1:0]   csr_mie_i,
  output logic              csr_we_o,
  output logic [CSR_AW-1:0] csr_waddr_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  output logic              stallreq_o,
  output logic              flush_o,
  output logic              jump_req_o,
  output logic [XLEN-1:0]   jump_pc_o,
  output logic              trap_active_o
);

  localparam int unsigned CodeW = (IRQ_W > 1) ? $clog2(IRQ_W) : 1;

  trap_state_e state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d, cause_q, cause_d, tval_q, tval_d, target_q, target_d;

  logic [IRQ_W-1:0] irq_en;
  logic             irq_valid;
  logic [CodeW-1:0] irq_code;
  logic             trap_evt, accept;
  logic [XLEN-1:0]  mtvec_base, mstatus_trap, mstatus_ret;

  assign irq_en = irq_i & csr_mie_i[IRQ_W-1:0] & {IRQ_W{csr_mstatus_i[MstatusMie]}};

  trap_irq_arb #(
    .IRQ_W (IRQ_W),
    .CodeW (CodeW)
  ) u_irq_arb (
    .req_i   (irq_en),
    .valid_o (irq_valid),
    .code_o  (irq_code)
  );

  assign trap_evt   = irq_valid | id_illegal_i | id_ebreak_i | id_ecall_i;
  // Gated by rst_n so every output reads 0 while reset is held.
  assign accept     = rst_n & (state_q == StIdle) & id_valid_i & ~pipe_busy_i &
                      (trap_evt | id_mret_i);
  assign mtvec_base = {csr_mtvec_i[XLEN-1:2], 2'b00};

  always_comb begin
    epc_d    = epc_q;
    cause_d  = cause_q;
    tval_d   = tval_q;
    target_d = target_q;
    if (accept && trap_evt) begin
      epc_d    = id_pc_i;
      cause_d  = '0;
      tval_d   = '0;
      target_d = mtvec_base;
      if (irq_valid) begin
        cause_d[XLEN-1]    = 1'b1;
        cause_d[CodeW-1:0] = irq_code;
        if (csr_mtvec_i[1:0] == 2'b01) begin
          target_d = mtvec_base + (XLEN'(irq_code) << 2);
        end
      end else if (id_illegal_i) begin
        cause_d = XLEN'(ExcIllegal);
        tval_d  = XLEN'(id_inst_i);
      end else if (id_ebreak_i) begin
        cause_d = XLEN'(ExcBreakpoint);
        tval_d  = id_pc_i;
      end else begin
        cause_d = XLEN'(ExcEcallM);
        epc_d   = id_pc_i + XLEN'(4);
      end
    end
  end

  always_comb begin
    mstatus_trap                            = csr_mstatus_i;
    mstatus_trap[MstatusMpie]               = csr_mstatus_i[MstatusMie];
    mstatus_trap[MstatusMie]                = 1'b0;
    mstatus_trap[MstatusMppHi:MstatusMppLo] = 2'b11;
    mstatus_ret                             = csr_mstatus_i;
    mstatus_ret[MstatusMie]                 = csr_mstatus_i[MstatusMpie];
    mstatus_ret[MstatusMpie]                = 1'b1;
    mstatus_ret[MstatusMppHi:MstatusMppLo]  = 2'b11;
  end

  always_comb begin
    state_d     = state_q;
    csr_we_o    = 1'b0;
    csr_waddr_o = '0;
    csr_wdata_o = '0;
    jump_req_o  = 1'b0;
    jump_pc_o   = '0;
    flush_o     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = trap_evt ? StWEpc : StWRet;
      end
      StWEpc: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_AW'(CsrMepc);
        csr_wdata_o = epc_q;
        state_d     = StWCause;
      end
      StWCause: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_AW'(CsrMcause);
        csr_wdata_o = cause_q;
        state_d     = StWTval;
      end
      StWTval: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_AW'(CsrMtval);
        csr_wdata_o = tval_q;
        state_d     = StWStat;
      end
      StWStat: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_AW'(CsrMstatus);
        csr_wdata_o = mstatus_trap;
        jump_req_o  = 1'b1;
        jump_pc_o   = target_q;
        flush_o     = 1'b1;
        state_d     = StIdle;
      end
      StWRet: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_AW'(CsrMstatus);
        csr_wdata_o = mstatus_ret;
        jump_req_o  = 1'b1;
        jump_pc_o   = csr_mepc_i;
        flush_o     = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign trap_active_o = (state_q != StIdle);
  assign stallreq_o    = accept | trap_active_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      epc_q    <= '0;
      cause_q  <= '0;
      tval_q   <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      tval_q   <= tval_d;
      target_q <= target_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: expected per-cycle outputs are queued at
// stimulus time and compared on the falling edge.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] irq_i;
  logic        id_valid_i;
  logic [31:0] id_pc_i, id_inst_i;
  logic        id_ecall_i, id_ebreak_i, id_illegal_i, id_mret_i, pipe_busy_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i, csr_mie_i;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        stallreq_o, flush_o, jump_req_o, trap_active_o;
  logic [31:0] jump_pc_o;

  trap_ctrl #(
    .XLEN   (32),
    .IRQ_W  (16),
    .CSR_AW (12)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .irq_i         (irq_i),
    .id_valid_i    (id_valid_i),
    .id_pc_i       (id_pc_i),
    .id_inst_i     (id_inst_i),
    .id_ecall_i    (id_ecall_i),
    .id_ebreak_i   (id_ebreak_i),
    .id_illegal_i  (id_illegal_i),
    .id_mret_i     (id_mret_i),
    .pipe_busy_i   (pipe_busy_i),
    .csr_mtvec_i   (csr_mtvec_i),
    .csr_mepc_i    (csr_mepc_i),
    .csr_mstatus_i (csr_mstatus_i),
    .csr_mie_i     (csr_mie_i),
    .csr_we_o      (csr_we_o),
    .csr_waddr_o   (csr_waddr_o),
    .csr_wdata_o   (csr_wdata_o),
    .stallreq_o    (stallreq_o),
    .flush_o       (flush_o),
    .jump_req_o    (jump_req_o),
    .jump_pc_o     (jump_pc_o),
    .trap_active_o (trap_active_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        stall;
    logic        active;
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
    logic        jump;
    logic [31:0] pc;
    logic        flush;
  } exp_t;

  exp_t sb[$];
  exp_t r;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   c;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push_rec(input int cy, input logic st, input logic ac, input logic we,
                          input logic [11:0] a, input logic [31:0] d, input logic j,
                          input logic [31:0] pc, input logic fl);
    exp_t e;
    e.cyc = cy; e.stall = st; e.active = ac; e.we = we; e.addr = a; e.data = d;
    e.jump = j; e.pc = pc; e.flush = fl;
    sb.push_back(e);
  endtask

  task automatic push_trap(input int c0, input logic [31:0] epc, input logic [31:0] cause,
                           input logic [31:0] tval, input logic [31:0] ms,
                           input logic [31:0] target);
    logic [31:0] ms_exp;
    ms_exp = (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0) | 32'h1800;
    push_rec(c0,     1, 0, 0, 12'h000, 32'h0,  0, 32'h0,  0);
    push_rec(c0 + 1, 1, 1, 1, 12'h341, epc,    0, 32'h0,  0);
    push_rec(c0 + 2, 1, 1, 1, 12'h342, cause,  0, 32'h0,  0);
    push_rec(c0 + 3, 1, 1, 1, 12'h343, tval,   0, 32'h0,  0);
    push_rec(c0 + 4, 1, 1, 1, 12'h300, ms_exp, 1, target, 1);
  endtask

  task automatic push_ret(input int c0, input logic [31:0] ms, input logic [31:0] mepc);
    logic [31:0] ms_exp;
    ms_exp = (ms & ~32'h88) | (ms[7] ? 32'h8 : 32'h0) | 32'h80 | 32'h1800;
    push_rec(c0,     1, 0, 0, 12'h000, 32'h0,  0, 32'h0, 0);
    push_rec(c0 + 1, 1, 1, 1, 12'h300, ms_exp, 1, mepc,  1);
  endtask

  task automatic clear_evt();
    id_valid_i = 0; id_ecall_i = 0; id_ebreak_i = 0; id_illegal_i = 0; id_mret_i = 0;
    irq_i = '0; pipe_busy_i = 0; id_inst_i = '0;
  endtask

  task automatic fire(input logic [31:0] pc, input logic [31:0] inst, input logic ec,
                      input logic eb, input logic il, input logic mr, input logic [15:0] irq,
                      output int c0);
    @(posedge clk); #1;
    id_valid_i = 1; id_pc_i = pc; id_inst_i = inst; id_ecall_i = ec; id_ebreak_i = eb;
    id_illegal_i = il; id_mret_i = mr; irq_i = irq;
    c0 = cyc;
  endtask

  task automatic drain();
    @(posedge clk); #1;
    clear_evt();
    repeat (6) @(posedge clk);
  endtask

  // Cycles with no queued expectation must be quiet.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      r = sb.pop_front();
      check_val("missed_rec", 128'(r.cyc), 128'(cyc));
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      r = sb.pop_front();
      check_val("stall",  128'(stallreq_o),    128'(r.stall));
      check_val("active", 128'(trap_active_o), 128'(r.active));
      check_val("we",     128'(csr_we_o),      128'(r.we));
      check_val("waddr",  128'(csr_waddr_o),   128'(r.addr));
      check_val("wdata",  128'(csr_wdata_o),   128'(r.data));
      check_val("jump",   128'(jump_req_o),    128'(r.jump));
      check_val("flush",  128'(flush_o),       128'(r.flush));
      if (r.jump) check_val("jump_pc", 128'(jump_pc_o), 128'(r.pc));
    end else begin
      check_val("idle", 128'({stallreq_o, trap_active_o, csr_we_o, jump_req_o, flush_o,
                              csr_waddr_o, csr_wdata_o}), 128'(0));
    end
  end

  initial begin
    rst_n = 0;
    clear_evt();
    id_pc_i = '0;
    csr_mtvec_i = 32'h200; csr_mepc_i = '0; csr_mstatus_i = 32'h8; csr_mie_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (2) @(posedge clk);

    // ecall; an ebreak mid-sequence must be ignored
    fire(32'h100, 32'h0, 1, 0, 0, 0, 16'h0, c);
    push_trap(c, 32'h104, 32'd11, 32'h0, 32'h8, 32'h200);
    @(posedge clk); #1 clear_evt();
    @(posedge clk); #1 id_valid_i = 1; id_ebreak_i = 1;
    drain();

    // vectored irq 7
    csr_mie_i = 32'h80; csr_mtvec_i = 32'h201;
    fire(32'h300, 32'h0, 0, 0, 0, 0, 16'h0080, c);
    push_trap(c, 32'h300, 32'h8000_0007, 32'h0, 32'h8, 32'h21C);
    drain();

    // irq 11 + 3 held off by pipe_busy for 3 cycles
    csr_mie_i = 32'h808; csr_mtvec_i = 32'h200;
    @(posedge clk); #1;
    id_valid_i = 1; id_pc_i = 32'h400; irq_i = 16'h0808; pipe_busy_i = 1;
    repeat (3) @(posedge clk);
    #1 pipe_busy_i = 0; c = cyc;
    push_trap(c, 32'h400, 32'h8000_000B, 32'h0, 32'h8, 32'h200);
    drain();

    // illegal + irq 3: interrupt wins; mtvec mode 2 behaves as direct
    csr_mie_i = 32'h8; csr_mtvec_i = 32'h202;
    fire(32'h500, 32'hFFFF_FFFF, 0, 0, 1, 0, 16'h0008, c);
    push_trap(c, 32'h500, 32'h8000_0003, 32'h0, 32'h8, 32'h200);
    drain();

    // same with MIE=0: illegal instruction taken
    csr_mstatus_i = 32'h0;
    fire(32'h500, 32'hFFFF_FFFF, 0, 0, 1, 0, 16'h0008, c);
    push_trap(c, 32'h500, 32'd2, 32'hFFFF_FFFF, 32'h0, 32'h200);
    drain();

    // ebreak at top of address space
    csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h200; csr_mie_i = '0;
    fire(32'hFFFF_FFFC, 32'h0, 0, 1, 0, 0, 16'h0, c);
    push_trap(c, 32'hFFFF_FFFC, 32'd3, 32'hFFFF_FFFC, 32'h8, 32'h200);
    drain();

    // ecall + mret together: ecall wins, epc wraps to 0
    fire(32'hFFFF_FFFC, 32'h0, 1, 0, 0, 1, 16'h0, c);
    push_trap(c, 32'h0, 32'd11, 32'h0, 32'h8, 32'h200);
    drain();

    // vectored irq 15 with wrapping handler address
    csr_mie_i = 32'h8000; csr_mtvec_i = 32'hFFFF_FFF1;
    fire(32'h600, 32'h0, 0, 0, 0, 0, 16'h8000, c);
    push_trap(c, 32'h600, 32'h8000_000F, 32'h0, 32'h8, 32'h0000_002C);
    drain();

    // mret
    csr_mie_i = '0; csr_mtvec_i = 32'h200; csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104;
    fire(32'h700, 32'h0, 0, 0, 0, 1, 16'h0, c);
    push_ret(c, 32'h80, 32'h104);
    drain();

    // reset asserted in W_CAUSE: no further writes
    csr_mstatus_i = 32'h8;
    fire(32'h100, 32'h0, 1, 0, 0, 0, 16'h0, c);
    push_rec(c,     1, 0, 0, 12'h000, 32'h0,   0, 32'h0, 0);
    push_rec(c + 1, 1, 1, 1, 12'h341, 32'h104, 0, 32'h0, 0);
    @(posedge clk); #1 clear_evt();
    @(posedge clk); #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (6) @(posedge clk);

    @(negedge clk);
    check_val("sb_empty", 128'(sb.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
